// File: rtl/mem_arbiter_pkg.sv
// Shared constants and types for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam int TEXT_BASE = 0;
  localparam int DATA_BASE = 2048;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the port that wins a tie.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (&req) grant = ptr ? 2'b10 : 2'b01;
  end

  // After any grant the other port gets the next tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= PORT_D;
    end else if (advance) begin
      ptr <= ~grant[PORT_D];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between fetch and load/store ports.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       owner_we;
  logic       rsp_we;
  logic       started;
  logic       rv_if;
  logic       rv_d;
  logic [1:0] grant;
  logic       win_d;
  logic       done;
  logic       issue;

  assign done  = (state == ST_WAIT) && (cnt == 4'd1);
  assign issue = started && ((state == ST_IDLE) || done)
              && (if_req || d_req);
  assign win_d = grant[PORT_D];

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({d_req, if_req}),
    .advance (issue),
    .grant   (grant)
  );

  // started blocks any issue on the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      owner     <= PORT_IF;
      owner_we  <= 1'b0;
      rsp_we    <= 1'b0;
      started   <= 1'b0;
      rv_if     <= 1'b0;
      rv_d      <= 1'b0;
      if_gnt    <= 1'b0;
      d_gnt     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      started <= 1'b1;
      if_gnt  <= 1'b0;
      d_gnt   <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      rv_if   <= 1'b0;
      rv_d    <= 1'b0;
      if (done) begin
        rv_if  <= (owner == PORT_IF);
        rv_d   <= (owner == PORT_D);
        rsp_we <= owner_we;
      end
      if (issue) begin
        if_gnt    <= ~win_d;
        d_gnt     <= win_d;
        mem_en    <= 1'b1;
        mem_we    <= win_d & d_we;
        mem_addr  <= win_d ? d_addr : if_addr;
        mem_wdata <= win_d ? d_wdata : '0;
        cnt       <= LAT;
        owner     <= win_d;
        owner_we  <= win_d & d_we;
        state     <= ST_WAIT;
      end else if (done) begin
        cnt   <= '0;
        state <= ST_IDLE;
      end else if (state == ST_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign if_rvalid = rv_if;
  assign d_rvalid  = rv_d;
  assign if_rdata  = rv_if ? mem_rdata : '0;
  assign d_rdata   = (rv_d && !rsp_we) ? mem_rdata : '0;
  assign busy      = (state == ST_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: instance a at MEM_LATENCY=1, instance b at MEM_LATENCY=3.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic        if_req_a = 0, d_req_a = 0, d_we_a = 0;
  logic [11:0] if_addr_a = 0, d_addr_a = 0;
  logic [31:0] d_wdata_a = 0;
  logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a;
  logic        mem_en_a, mem_we_a, busy_a;
  logic [31:0] if_rdata_a, d_rdata_a, mem_wdata_a, mem_rdata_a;
  logic [11:0] mem_addr_a;

  logic        if_req_b = 0, d_req_b = 0, d_we_b = 0;
  logic [11:0] if_addr_b = 0, d_addr_b = 0;
  logic [31:0] d_wdata_b = 0;
  logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b;
  logic        mem_en_b, mem_we_b, busy_b;
  logic [31:0] if_rdata_b, d_rdata_b, mem_wdata_b;
  logic [11:0] mem_addr_b;

  logic        ld_en = 0;
  logic [11:0] ld_addr = 0;
  logic [31:0] ld_data = 0;
  logic [31:0] mem_a [4096];
  logic [31:0] mem_b [4096];
  logic [31:0] p0, p1, p2;

  mem_arbiter #(.MEM_LATENCY(1)) u_a (
    .clk(clk), .reset(reset),
    .if_req(if_req_a), .if_addr(if_addr_a),
    .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a),
    .d_wdata(d_wdata_a), .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a),
    .d_rdata(d_rdata_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
    .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .busy(busy_a)
  );

  mem_arbiter #(.MEM_LATENCY(3)) u_b (
    .clk(clk), .reset(reset),
    .if_req(if_req_b), .if_addr(if_addr_b),
    .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b),
    .d_wdata(d_wdata_b), .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b),
    .d_rdata(d_rdata_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
    .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(p2), .busy(busy_b)
  );

  always @(posedge clk) begin
    if (ld_en) begin
      mem_a[ld_addr] <= ld_data;
      mem_b[ld_addr] <= ld_data;
    end else begin
      if (mem_en_a && mem_we_a) mem_a[mem_addr_a] <= mem_wdata_a;
      if (mem_en_b && mem_we_b) mem_b[mem_addr_b] <= mem_wdata_b;
    end
    mem_rdata_a <= mem_a[mem_addr_a];
    p0 <= mem_b[mem_addr_b];
    p1 <= p0;
    p2 <= p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk(tag, {if_gnt_a, if_rvalid_a, if_rdata_a, d_gnt_a, d_rvalid_a,
              d_rdata_a, mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a,
              busy_a}, '0);
  endtask

  logic [11:0] ld_tab_a [6] = '{12'd0, 12'd1, 12'd2, 12'd3, 12'd5, 12'd2048};
  logic [31:0] ld_tab_d [6] = '{32'h20080005, 32'h11111111, 32'h22222222,
                                32'h33333333, 32'h55555555, 32'h0};
  logic [31:0] b2b [4] = '{32'h20080005, 32'h11111111, 32'h22222222,
                           32'h33333333};

  initial begin
    for (int i = 0; i < 6; i++) begin
      ld_en = 1; ld_addr = ld_tab_a[i]; ld_data = ld_tab_d[i];
      tick();
    end
    ld_en = 0;
    tick();
    chk_outs_zero("reset_outs");
    chk("reset_busy_b", {busy_b, d_gnt_b, mem_en_b}, 0);

    // single fetch
    reset = 1;
    if_req_a = 1; if_addr_a = 12'(TEXT_BASE);
    tick();
    chk("first_cycle_no_gnt", {if_gnt_a, d_gnt_a, mem_en_a}, 0);
    tick();
    chk("fetch_gnt", {if_gnt_a, d_gnt_a, mem_en_a, mem_we_a, busy_a}, 5'b10101);
    chk("fetch_addr", mem_addr_a, 0);
    if_req_a = 0;
    tick();
    chk("fetch_rvalid", {if_rvalid_a, d_rvalid_a, if_gnt_a}, 3'b100);
    chk("fetch_rdata", if_rdata_a, 32'h20080005);
    chk("fetch_d_rdata", d_rdata_a, 0);

    // data write then read
    d_req_a = 1; d_we_a = 1; d_addr_a = 12'(DATA_BASE);
    d_wdata_a = 32'hDEADBEEF;
    tick();
    chk("wr_gnt", {d_gnt_a, if_gnt_a, mem_en_a, mem_we_a}, 4'b1011);
    chk("wr_bus", {mem_addr_a, mem_wdata_a}, {12'd2048, 32'hDEADBEEF});
    d_req_a = 0;
    tick();
    chk("wr_ack", {d_rvalid_a, if_rvalid_a, d_rdata_a}, {2'b10, 32'h0});
    d_req_a = 1; d_we_a = 0;
    tick();
    chk("rd_gnt", {d_gnt_a, mem_en_a, mem_we_a}, 3'b110);
    d_req_a = 0;
    tick();
    chk("rd_data", {d_rvalid_a, d_rdata_a}, {1'b1, 32'hDEADBEEF});

    // simultaneous requests straight out of reset
    reset = 0;
    #1;
    chk_outs_zero("reset2_outs");
    if_req_a = 1; if_addr_a = 12'd1;
    d_req_a = 1; d_we_a = 0; d_addr_a = 12'd2048;
    tick();
    reset = 1;
    tick();
    chk("rr_guard", {if_gnt_a, d_gnt_a}, 0);
    tick();
    chk("rr_g1_d", {d_gnt_a, if_gnt_a}, 2'b10);
    tick();
    chk("rr_g2_if", {d_gnt_a, if_gnt_a}, 2'b01);
    chk("rr_r1_d", {d_rvalid_a, if_rvalid_a, d_rdata_a},
        {2'b10, 32'hDEADBEEF});
    tick();
    chk("rr_g3_d", {d_gnt_a, if_gnt_a}, 2'b10);
    chk("rr_r2_if", {if_rvalid_a, d_rvalid_a, if_rdata_a, d_rdata_a},
        {2'b10, 32'h11111111, 32'h0});
    tick();
    chk("rr_g4_if", {d_gnt_a, if_gnt_a}, 2'b01);
    chk("rr_r3_d", {d_rvalid_a, if_rvalid_a, d_rdata_a, if_rdata_a},
        {2'b10, 32'hDEADBEEF, 32'h0});
    if_req_a = 0; d_req_a = 0;
    tick();
    chk("rr_r4_if", {if_rvalid_a, if_rdata_a}, {1'b1, 32'h11111111});
    chk("rr_idle", {busy_a, if_gnt_a, d_gnt_a}, 0);

    // reset during an outstanding fetch
    if_req_a = 1; if_addr_a = 12'd2;
    tick();
    chk("abort_gnt", {if_gnt_a, busy_a}, 2'b11);
    if_req_a = 0;
    #2;
    reset = 0;
    #1;
    chk_outs_zero("abort_outs");
    tick();
    chk("abort_no_rv1", {if_rvalid_a, d_rvalid_a}, 0);
    reset = 1;
    if_req_a = 1; if_addr_a = 12'd3;
    tick();
    chk("abort_no_rv2", {if_rvalid_a, d_rvalid_a, if_gnt_a}, 0);
    tick();
    chk("abort_next_gnt", if_gnt_a, 1);
    if_req_a = 0;
    tick();
    chk("abort_next_rv", {if_rvalid_a, if_rdata_a}, {1'b1, 32'h33333333});

    // back-to-back fetches of words 0..3
    if_req_a = 1; if_addr_a = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("b2b_gnt", if_gnt_a, (i < 4));
      chk("b2b_rvalid", if_rvalid_a, (i > 0));
      if (i > 0) chk("b2b_rdata", if_rdata_a, b2b[i-1]);
      if (i < 3) if_addr_a = 12'(i + 1);
      else if_req_a = 0;
    end

    // latency 3 read with request held
    d_req_b = 1; d_we_b = 0; d_addr_b = 12'd5;
    tick();
    chk("l3_gnt", {d_gnt_b, busy_b, mem_en_b}, 3'b111);
    tick();
    chk("l3_wait1", {d_gnt_b, d_rvalid_b, busy_b}, 3'b001);
    tick();
    chk("l3_wait2", {d_gnt_b, d_rvalid_b, busy_b}, 3'b001);
    tick();
    chk("l3_resp", {d_rvalid_b, d_rdata_b}, {1'b1, 32'h55555555});
    chk("l3_regnt", {d_gnt_b, busy_b}, 2'b11);
    d_req_b = 0;
    tick();
    tick();
    chk("l3_wait3", {d_rvalid_b, busy_b}, 2'b01);
    tick();
    chk("l3_resp2", {d_rvalid_b, d_rdata_b}, {1'b1, 32'h55555555});
    tick();
    chk("l3_idle", {busy_b, d_rvalid_b, if_rvalid_b}, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-ported unified word-addressed memory between the CPU instruction-fetch port and the load/store data port.
- Memory map: .text at word 0, .data at word 2048 (byte 0x2000).
- Issues one memory access at a time, tracks its fixed read latency and routes the response to the requester that issued it.
- Round-robin arbitration between the two ports, so neither can starve the other.

Parameters:
- ADDR_W, 12, word address width (4096 words).
- DATA_W, 32, data word width.
- MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; hold with stable if_addr until if_gnt.
- if_addr  in  ADDR_W  fetch word address.
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; hold with stable d_we, d_addr, d_wdata until d_gnt.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid, or write complete.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en.
- busy  out  1  high while an access is outstanding.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0, state IDLE, latency counter 0.
  - Priority pointer = DATA.
  - Any in-flight access is discarded: no rvalid is ever issued for it.
  - Memory writes already strobed are not undone.
- FSM has two states: IDLE and WAIT.
- Issue cycle (IDLE with any request, or WAIT on its response cycle):
  - Registered outputs for the winner: gnt = 1, mem_en = 1, mem_we = (winner is DATA) & d_we.
  - mem_addr and mem_wdata from the winner; the fetch port never writes.
  - Load counter = MEM_LATENCY, record owner, go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - Response cycle (counter reaches 0): owner's rvalid = 1 and owner's rdata = mem_rdata.
  - The other port's rdata is held at 0.
  - Same cycle: if a request is pending, a new issue occurs and the FSM stays in WAIT; otherwise return to IDLE.
  - Throughput: one access per MEM_LATENCY cycles. At MEM_LATENCY = 1, back-to-back accesses run every cycle.
- Arbitration:
  - If only one request is present, that port wins.
  - If both are present, the pointer's port wins; the pointer then flips to the loser.
  - A single-requester grant also sets the pointer to the other port.
- Writes:
  - d_rvalid pulses on the response cycle as a completion ack.
  - d_rdata = 0 for writes.
- gnt, mem_en and rvalid are single-cycle pulses. They are never asserted during reset or the first cycle after reset release.
- A request dropped before its gnt is legal and has no effect.
- A request for the same port held high after its gnt is treated as a new request.
- busy = (state == WAIT).
- No address range check. Addresses wrap at 2^ADDR_W.

Decomposition:
- Shared package holds:
  - port-id constants PORT_IF = 0, PORT_D = 1;
  - FSM state encodings ST_IDLE, ST_WAIT;
  - word-address constants TEXT_BASE = 0, DATA_BASE = 2048.
- One natural sub-module: rr_arbiter2, a 2-way round-robin arbiter holding the pointer register, with inputs req[1:0] and advance, output grant one-hot.

Test Plan:
- Single fetch, MEM_LATENCY = 1, mem[0] = 0x20080005, if_addr = 0 → if_gnt at cycle t, if_rvalid at t+1 with if_rdata = 0x20080005; d_rvalid stays 0.
- Data write then read, d_addr = 2048, d_wdata = 0xDEADBEEF → write: mem_we = 1 on the issue cycle, then d_rvalid with d_rdata = 0. Following read: d_rdata = 0xDEADBEEF.
- Simultaneous if_req and d_req held for 4 grants, immediately after reset → grant order D, IF, D, IF; responses routed to the matching ports.
- MEM_LATENCY = 3, single read → rvalid exactly 3 cycles after gnt; busy high for those 3 cycles; no second grant before the response cycle.
- Reset asserted one cycle after a grant → all outputs 0 immediately. After release, no rvalid for the aborted access; the next request is served normally.
- Back-to-back fetches of words 0..3, MEM_LATENCY = 1 → gnt on 4 consecutive cycles, rvalid on the 4 following cycles with the correct data, in order.
